// File: rtl/bm_mem.sv
// Bitmatrix column memory: fixed-latency pipelined column reads for bm_cntl, plus a
// host-side load FSM that assembles HOST_W beats into one BM_COL_W column.
module bm_mem #(
    parameter  int W             = 8,
    parameter  int K_MAX         = 8,
    localparam int BM_COL_W      = W * W * K_MAX,
    parameter  int BM_DEPTH      = 16,
    parameter  int BM_MEM_ADDR_W = 4,
    parameter  int HOST_W        = 32,
    localparam int BEATS         = BM_COL_W / HOST_W,
    parameter  int RD_LAT        = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     eng_rstn,
    input  logic                     bm_cntl_bm_mem_rd_rq,
    input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
    output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
    output logic                     bm_mem_bm_cntl_rd_data_val,
    output logic                     bm_mem_rd_err,
    input  logic                     host_bm_mem_wr_start,
    input  logic [BM_MEM_ADDR_W-1:0] host_bm_mem_wr_addr,
    input  logic                     host_bm_mem_wr_en,
    input  logic [HOST_W-1:0]        host_bm_mem_wr_data,
    input  logic                     host_bm_mem_wr_abort,
    output logic                     bm_mem_host_wr_rdy,
    output logic                     bm_mem_host_wr_done,
    output logic                     bm_mem_host_busy,
    output logic [1:0]               bm_mem_dbg_state
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         beat_cnt_q;
    logic [BM_MEM_ADDR_W-1:0] wr_addr_q;
    logic [BM_COL_W-1:0]      staging_q;
    logic [BM_COL_W-1:0]      mem_q [BM_DEPTH];
    logic [RD_LAT-1:0]        rd_vld_q;
    logic [BM_COL_W-1:0]      rd_dat_q [RD_LAT];
    logic                     rd_err_q;
    logic [BM_COL_W-1:0]      rd_col;
    logic                     rd_hit;
    logic                     beat_acc;
    logic                     last_beat;

    // Host beats transfer on a cycle with wr_en && wr_rdy (rdy is high only in LOAD);
    // the read side has no ready: every rd_rq is accepted and answered RD_LAT later.
    assign beat_acc  = (state_q == ST_LOAD) && host_bm_mem_wr_en && !host_bm_mem_wr_abort;
    assign last_beat = beat_acc && (beat_cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (host_bm_mem_wr_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (host_bm_mem_wr_abort) state_d = ST_IDLE;
                else if (last_beat)       state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bm_mem_host_wr_rdy  = 1'b0;
        bm_mem_host_busy    = 1'b0;
        bm_mem_host_wr_done = 1'b0;
        case (state_q)
            ST_LOAD: begin
                bm_mem_host_wr_rdy = 1'b1;
                bm_mem_host_busy   = 1'b1;
            end
            ST_COMMIT: begin
                bm_mem_host_busy    = 1'b1;
                bm_mem_host_wr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bm_mem_dbg_state = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q <= '0;
            wr_addr_q  <= '0;
            staging_q  <= '0;
        end else if ((state_q == ST_IDLE) && host_bm_mem_wr_start) begin
            beat_cnt_q <= '0;
            wr_addr_q  <= host_bm_mem_wr_addr;
            staging_q  <= '0;
        end else if (beat_acc) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_cnt_q == CNT_W'(b)) staging_q[b*HOST_W +: HOST_W] <= host_bm_mem_wr_data;
            end
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
    end

    // Commit to an address with no matching entry simply writes nothing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BM_DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == ST_COMMIT) begin
            for (int i = 0; i < BM_DEPTH; i++) begin
                if (wr_addr_q == BM_MEM_ADDR_W'(i)) mem_q[i] <= staging_q;
            end
        end
    end

    always_comb begin
        rd_col = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < BM_DEPTH; i++) begin
            if (bm_cntl_bm_mem_rd_addr == BM_MEM_ADDR_W'(i)) begin
                rd_col = mem_q[i];
                rd_hit = 1'b1;
            end
        end
    end

    // Data stages only advance behind a valid, so the last stage holds between responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_vld_q <= '0;
            rd_err_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) rd_dat_q[i] <= '0;
        end else if (!eng_rstn) begin
            rd_vld_q <= '0;
            rd_err_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) rd_dat_q[i] <= '0;
        end else begin
            rd_vld_q[0] <= bm_cntl_bm_mem_rd_rq;
            if (bm_cntl_bm_mem_rd_rq) rd_dat_q[0] <= rd_col;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                if (rd_vld_q[i-1]) rd_dat_q[i] <= rd_dat_q[i-1];
            end
            if (bm_cntl_bm_mem_rd_rq && !rd_hit) rd_err_q <= 1'b1;
        end
    end

    assign bm_mem_bm_cntl_rd_data     = rd_dat_q[RD_LAT-1];
    assign bm_mem_bm_cntl_rd_data_val = rd_vld_q[RD_LAT-1];
    assign bm_mem_rd_err              = rd_err_q;

endmodule

// File: doc/bm_mem.md
Name: bm_mem

Overview:
- Bitmatrix column memory: the responder on the bitmatrix memory read interface driven by the bitmatrix controller (bm_cntl). It stores one BM_COL_W-bit column per entry.
- Reads are served with a fixed latency and a data-valid pulse.
- Columns are loaded from the host/config side through a narrow HOST_W bus by a beat-assembling load FSM.

Parameters:
- W, 8, symbol width in bits.
- K_MAX, 8, maximum number of data chunks.
- BM_COL_W, W*W*K_MAX (512), width of one column entry; derived, do not override.
- BM_DEPTH, 16, number of column entries.
- BM_MEM_ADDR_W, 4, entry address width; must satisfy 2^BM_MEM_ADDR_W >= BM_DEPTH.
- HOST_W, 32, host load bus width; BM_COL_W must be a multiple of HOST_W.
- BEATS, BM_COL_W/HOST_W (16), beats per column; derived.
- RD_LAT, 2, read latency in cycles, minimum 1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- eng_rstn  in  1  synchronous active-low engine soft reset
- bm_cntl_bm_mem_rd_rq  in  1  read request, one per cycle
- bm_cntl_bm_mem_rd_addr  in  BM_MEM_ADDR_W  read entry address
- bm_mem_bm_cntl_rd_data  out  BM_COL_W  read data
- bm_mem_bm_cntl_rd_data_val  out  1  read data valid, one-cycle pulse per request
- bm_mem_rd_err  out  1  sticky out-of-range read flag
- host_bm_mem_wr_start  in  1  start a column load
- host_bm_mem_wr_addr  in  BM_MEM_ADDR_W  target entry, sampled on start
- host_bm_mem_wr_en  in  1  beat valid
- host_bm_mem_wr_data  in  HOST_W  beat data
- host_bm_mem_wr_abort  in  1  abandon the current load
- bm_mem_host_wr_rdy  out  1  beat accept ready
- bm_mem_host_wr_done  out  1  one-cycle pulse when a column is committed
- bm_mem_host_busy  out  1  load FSM not in IDLE

Behaviour:
- Reset (rstn low):
  - All memory entries, the staging register, the read pipeline and bm_mem_rd_err are cleared to 0.
  - All outputs are 0 and the FSM is in IDLE.
- eng_rstn low:
  - Flushes the read pipeline: rd_data_val=0 and rd_data=0 on the next cycle; requests in flight are dropped.
  - Clears bm_mem_rd_err.
  - Does not affect memory contents or the load FSM.
- Read path:
  - A request is captured when rd_rq=1.
  - Exactly RD_LAT cycles later, rd_data_val=1 for one cycle and rd_data=mem[addr] as sampled at the request cycle.
  - The path is fully pipelined: back-to-back requests produce back-to-back valids in request order.
  - There is no backpressure.
  - rd_data holds its last value when val=0.
- Out-of-range read (addr >= BM_DEPTH):
  - The response is still returned with val=1 and data all zeros.
  - bm_mem_rd_err is set and stays set until rstn or eng_rstn.
- Load FSM states: IDLE, LOAD, COMMIT.
  - IDLE: rdy=0, busy=0. On wr_start, latch wr_addr, clear beat_cnt and the staging register, go to LOAD. wr_start in any other state is ignored.
  - LOAD: rdy=1, busy=1.
    - A beat is accepted when wr_en=1; its data is written to staging[beat_cnt*HOST_W +: HOST_W] and beat_cnt increments.
    - The beat accepted with beat_cnt==BEATS-1 moves the FSM to COMMIT.
    - wr_abort=1 returns the FSM to IDLE with no memory write. Abort wins over a same-cycle beat.
  - COMMIT: rdy=0, busy=1. Writes staging to mem[latched addr] (writes to an address >= BM_DEPTH are dropped), pulses wr_done, returns to IDLE. Lasts exactly one cycle.
- Read/write collision: a read captured in the COMMIT cycle to the same entry returns the old contents (read-before-write). The new data is visible to requests issued from the next cycle onward.
- beat_cnt is log2(BEATS) bits wide; it never wraps inside LOAD, because reaching the final beat exits to COMMIT.
- If rstn is asserted mid-load, the FSM returns to IDLE and the partially loaded column is discarded.

Test Plan:
- Reset: after rstn deassert, all outputs = 0, busy=0, rdy=0; a read of entry 3 returns 512'h0 at t+2 with val=1.
- Load entry 5 with 16 beats 32'h0000_0000..32'h0000_000F:
  - wr_done pulses one cycle after beat 15.
  - A read of addr 5 returns word i = i for i = 0..15, 2 cycles after rq.
- Back-to-back reads of addr 1, 2, 1 with distinct patterns loaded: three consecutive val pulses carry the correct data in order; no bubbles.
- Abort: load entry 7 (pattern 0xA5 bytes), abort after 6 beats, issuing a beat in the same cycle.
  - FSM returns to IDLE.
  - mem[7] is unchanged (0).
  - No wr_done pulse.
- Collision: issue a read of entry 2 in the COMMIT cycle of a load to entry 2 → old data returned; a read issued the next cycle → new data.
- Out-of-range and soft reset:
  - A read of addr 4'hF with BM_DEPTH=12 → val=1, data 0, rd_err=1 (sticky).
  - eng_rstn pulsed with two reads in flight → no val pulses; rd_err cleared; memory contents retained.
